// File: rtl/ccff_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_loader
// Brief    : Serialises bitstream bytes onto a configuration flop chain and
//            reads the chain back non-destructively by recirculating its tail.
// Revision : 1.0
// ============================================================================
module ccff_loader #(
  parameter int CHAIN_LEN = 36
) (
  input  logic       prog_clk,
  input  logic       prog_reset,
  input  logic       cmd_load,
  input  logic       cmd_readback,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       ccff_head,
  input  logic       ccff_tail,
  output logic       chain_clk_en,
  output logic       busy,
  output logic       done,
  output logic       cfg_valid,
  output logic       cmd_err
);

  localparam int NBYTES = (CHAIN_LEN + 7) / 8;
  localparam int PAD    = 8 * NBYTES - CHAIN_LEN;
  localparam int CW     = $clog2(8 * NBYTES + 1);

  localparam logic [CW-1:0] C_NBYTES    = CW'(NBYTES);
  localparam logic [CW-1:0] C_LAST_LOAD = CW'(8 * NBYTES - 1);
  localparam logic [CW-1:0] C_CHAIN_LEN = CW'(CHAIN_LEN);
  localparam logic [3:0]    C_PAD       = 4'(PAD);
  localparam logic [3:0]    C_FULL      = 4'd8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RDBK = 2'd2;

  logic [1:0]    state_q,     state_d;
  logic [7:0]    in_sr_q,     in_sr_d;
  logic [3:0]    in_cnt_q,    in_cnt_d;
  logic [CW-1:0] byte_cnt_q,  byte_cnt_d;
  logic [CW-1:0] chain_cnt_q, chain_cnt_d;
  logic [7:0]    out_sr_q,    out_sr_d;
  logic [3:0]    out_cnt_q,   out_cnt_d;
  logic          done_q,      done_d;
  logic          cfg_valid_q, cfg_valid_d;
  logic          cmd_err_q,   cmd_err_d;

  logic w_load_shift;
  logic w_rd_shift;
  logic w_in_hs;
  logic w_out_hs;

  // State register
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q     <= ST_IDLE;
      in_sr_q     <= 8'h00;
      in_cnt_q    <= 4'd0;
      byte_cnt_q  <= '0;
      chain_cnt_q <= '0;
      out_sr_q    <= 8'h00;
      out_cnt_q   <= 4'd0;
      done_q      <= 1'b0;
      cfg_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_sr_q     <= in_sr_d;
      in_cnt_q    <= in_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      chain_cnt_q <= chain_cnt_d;
      out_sr_q    <= out_sr_d;
      out_cnt_q   <= out_cnt_d;
      done_q      <= done_d;
      cfg_valid_q <= cfg_valid_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_load) begin
          state_d = ST_LOAD;
        end else if (cmd_readback) begin
          state_d = ST_RDBK;
        end
      end
      ST_LOAD: begin
        if (w_load_shift && (chain_cnt_q == C_LAST_LOAD)) begin
          state_d = ST_IDLE;
        end
      end
      ST_RDBK: begin
        if (w_out_hs && (chain_cnt_q == C_CHAIN_LEN)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and status next values
  always_comb begin
    in_sr_d     = in_sr_q;
    in_cnt_d    = in_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    chain_cnt_d = chain_cnt_q;
    out_sr_d    = out_sr_q;
    out_cnt_d   = out_cnt_q;
    done_d      = 1'b0;
    cfg_valid_d = cfg_valid_q;
    cmd_err_d   = cmd_err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_load) begin
          in_cnt_d    = 4'd0;
          byte_cnt_d  = '0;
          chain_cnt_d = '0;
          cfg_valid_d = 1'b0;
        end else if (cmd_readback) begin
          // Pad positions are pre-counted so the first byte comes out right-aligned
          chain_cnt_d = '0;
          out_cnt_d   = C_PAD;
          out_sr_d    = 8'h00;
        end
      end
      ST_LOAD: begin
        if (w_in_hs) begin
          in_sr_d    = in_data;
          in_cnt_d   = C_FULL;
          byte_cnt_d = byte_cnt_q + 1'b1;
        end else if (w_load_shift) begin
          in_sr_d     = {in_sr_q[6:0], 1'b0};
          in_cnt_d    = in_cnt_q - 1'b1;
          chain_cnt_d = chain_cnt_q + 1'b1;
          if (chain_cnt_q == C_LAST_LOAD) begin
            done_d      = 1'b1;
            cfg_valid_d = 1'b1;
          end
        end
      end
      ST_RDBK: begin
        if (w_rd_shift) begin
          out_sr_d    = {out_sr_q[6:0], ccff_tail};
          out_cnt_d   = out_cnt_q + 1'b1;
          chain_cnt_d = chain_cnt_q + 1'b1;
        end else if (w_out_hs) begin
          out_cnt_d = 4'd0;
          if (chain_cnt_q == C_CHAIN_LEN) begin
            done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if ((state_q != ST_IDLE) && (cmd_load || cmd_readback)) begin
      cmd_err_d = 1'b1;
    end
  end

  // Outputs
  always_comb begin
    w_load_shift = (state_q == ST_LOAD) && (in_cnt_q != 4'd0);
    w_rd_shift   = (state_q == ST_RDBK) && (out_cnt_q < C_FULL)
                   && (chain_cnt_q < C_CHAIN_LEN);
    in_ready     = (state_q == ST_LOAD) && (in_cnt_q == 4'd0)
                   && (byte_cnt_q < C_NBYTES);
    out_valid    = (state_q == ST_RDBK) && (out_cnt_q == C_FULL);
    w_in_hs      = in_ready && in_valid;
    w_out_hs     = out_valid && out_ready;
    chain_clk_en = w_load_shift || w_rd_shift;
    // Readback recirculates the tail so the chain ends where it started
    ccff_head    = (state_q == ST_RDBK) ? ccff_tail : in_sr_q[7];
    out_data     = out_sr_q;
    busy         = (state_q != ST_IDLE);
    done         = done_q;
    cfg_valid    = cfg_valid_q;
    cmd_err      = cmd_err_q;
  end

endmodule
`default_nettype wire
